// File: rtl/hilo_unit.sv
// HI/LO register file and multiply/divide sequencer for the multicycle core.
// Optional wait timeout is compiled in with `define HILO_TIMEOUT_EN.
module hilo_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_data_i,
  output logic        req_ready_o,
  output logic        mult_start_o,
  input  logic [31:0] mult_hi_i,
  input  logic [31:0] mult_lo_i,
  input  logic        mult_done_i,
  output logic        div_start_o,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  input  logic        div_done_i,
  input  logic        div_zero_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        div_zero_err_o,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {StIdle, StWaitMult, StWaitDiv} state_e;

  localparam logic [1:0] OpMult = 2'b00;
  localparam logic [1:0] OpDiv  = 2'b01;
  localparam logic [1:0] OpMthi = 2'b10;
  localparam logic [1:0] OpMtlo = 2'b11;

  state_e      state_q;
  logic [31:0] hi_q, lo_q;
  logic        mult_start_q, div_start_q;
  logic        div_zero_err_q;

  // A done strobe in the same cycle as our own start pulse belongs to an older op.
  logic mult_fire, div_fire;
  assign mult_fire = mult_done_i && !mult_start_q;
  assign div_fire  = div_done_i && !div_start_q;

`ifdef HILO_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_err_q;
  logic        expired;
  assign expired = (wait_cnt_q == TIMEOUT_CYCLES - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      hi_q           <= '0;
      lo_q           <= '0;
      mult_start_q   <= 1'b0;
      div_start_q    <= 1'b0;
      div_zero_err_q <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      wait_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef HILO_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          if (req_valid_i) begin
            unique case (req_op_i)
              OpMult: begin
                state_q      <= StWaitMult;
                mult_start_q <= 1'b1;
              end
              OpDiv: begin
                state_q        <= StWaitDiv;
                div_start_q    <= 1'b1;
                div_zero_err_q <= 1'b0;
              end
              OpMthi: hi_q <= req_data_i;
              OpMtlo: lo_q <= req_data_i;
              default: ;
            endcase
          end
        end
        StWaitMult: begin
          if (mult_fire) begin
            hi_q    <= mult_hi_i;
            lo_q    <= mult_lo_i;
            state_q <= StIdle;
          end
`ifdef HILO_TIMEOUT_EN
          else if (expired) begin
            state_q       <= StIdle;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
`endif
        end
        StWaitDiv: begin
          if (div_fire) begin
            if (div_zero_i) begin
              div_zero_err_q <= 1'b1;
            end else begin
              hi_q <= div_hi_i;
              lo_q <= div_lo_i;
            end
            state_q <= StIdle;
          end
`ifdef HILO_TIMEOUT_EN
          else if (expired) begin
            state_q       <= StIdle;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HILO_TIMEOUT_EN
  assign timeout_err_o = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err_o      = 1'b0;
`endif

  assign req_ready_o    = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign mult_start_o   = mult_start_q;
  assign div_start_o    = div_start_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign div_zero_err_o = div_zero_err_q;

endmodule
